// File: rtl/log2_iter.sv
// log2_iter: streaming base-2 log with leading-one normalisation and iterative squaring for the fraction.
module log2_iter #(
    parameter int I_WIDTH   = 64,
    parameter int O_WIDTH_F = 8,
    parameter int M_WIDTH   = 16,
    parameter int O_WIDTH   = O_WIDTH_F + $clog2(I_WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic [I_WIDTH-1:0] i_data,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [O_WIDTH-1:0] o_data,
    output logic               o_zero,
    output logic               busy
);
    localparam int LW = $clog2(I_WIDTH);
    localparam int CW = $clog2(O_WIDTH_F + 1);
    localparam logic [1:0] IDLE = 2'd0, NORM = 2'd1, ITER = 2'd2, DONE = 2'd3;

    logic [1:0]             state;
    logic [I_WIDTH-1:0]     data_r;
    logic [LW-1:0]          int_part, msb, lz;
    logic [O_WIDTH_F-1:0]   frac;
    logic [M_WIDTH:0]       m, m_norm, m_next;
    logic [2*M_WIDTH+1:0]   m_wide;
    logic [M_WIDTH+1:0]     sq_hi;
    logic [CW-1:0]          cnt;
    logic                   zero;

    always_comb begin
        msb = '0;
        for (int i = 0; i < I_WIDTH; i++)
            if (data_r[i]) msb = LW'(i);
    end

    // Shift the leading one to the top, then keep it plus M_WIDTH bits below (zero-filled if short).
    assign lz     = LW'(I_WIDTH - 1) - msb;
    assign m_norm = (M_WIDTH+1)'({data_r << lz, {M_WIDTH{1'b0}}} >> (I_WIDTH - 1));

    // Only the upper M_WIDTH+2 bits of m*m matter: the overflow bit and the renormalised mantissa.
    assign m_wide = {{(M_WIDTH+1){1'b0}}, m};
    assign sq_hi  = (M_WIDTH+2)'((m_wide * m_wide) >> M_WIDTH);
    assign m_next = sq_hi[M_WIDTH+1] ? sq_hi[M_WIDTH+1:1] : sq_hi[M_WIDTH:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            data_r   <= '0;
            int_part <= '0;
            frac     <= '0;
            m        <= '0;
            cnt      <= '0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    data_r <= i_data;
                    state  <= NORM;
                end
                NORM: begin
                    cnt      <= '0;
                    frac     <= '0;
                    zero     <= data_r == '0;
                    int_part <= msb;
                    m        <= m_norm;
                    state    <= data_r == '0 ? DONE : ITER;
                end
                ITER: begin
                    m     <= m_next;
                    frac  <= O_WIDTH_F'({frac, sq_hi[M_WIDTH+1]});
                    cnt   <= cnt + 1'b1;
                    state <= cnt == CW'(O_WIDTH_F - 1) ? DONE : ITER;
                end
                default: if (o_ready) state <= IDLE;
            endcase
        end
    end

    assign i_ready = state == IDLE;
    assign o_valid = state == DONE;
    assign busy    = state != IDLE;
    assign o_data  = {int_part, frac};
    assign o_zero  = zero;
endmodule

// File: tb/tb_log2_iter.sv
// tb_log2_iter: directed vectors against an arithmetic log2 model with a per-cycle output scoreboard.
module tb_log2_iter;
    logic        clk = 1'b0;
    logic        rst, i_valid, o_ready;
    logic [63:0] i_data;
    logic        i_ready, o_valid, o_zero, busy;
    logic [13:0] o_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit seen = 0;

    typedef struct {
        logic [13:0] d;
        logic        z;
        int          lat;
        int          acc;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    log2_iter dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
        .o_zero(o_zero), .busy(busy)
    );

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // {zero, int, frac}: log2 as msb index plus fraction bits from repeated squaring of the 1.16 mantissa
    function automatic logic [14:0] model(logic [63:0] x);
        int p = 0;
        longint unsigned m, sq;
        logic [7:0] f = 8'd0;
        if (x == 64'd0) return 15'h4000;
        for (int i = 0; i < 64; i++) if (x[i]) p = i;
        m = (p >= 16) ? (x >> (p - 16)) : (x << (16 - p));
        for (int k = 0; k < 8; k++) begin
            sq = m * m;
            if ((sq >> 33) != 0) begin
                f = {f[6:0], 1'b1};
                m = sq >> 17;
            end else begin
                f = {f[6:0], 1'b0};
                m = sq >> 16;
            end
        end
        return {1'b0, p[5:0], f};
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            seen = 0;
        end else begin
            check("busy_vs_iready", busy, !i_ready);
            if (o_valid) begin
                if (q.size() == 0) check("unexpected_valid", o_valid, 0);
                else begin
                    check("o_data", o_data, q[0].d);
                    check("o_zero", o_zero, q[0].z);
                    check("iready_in_done", i_ready, 0);
                    if (!seen) check("latency", cyc - q[0].acc, q[0].lat);
                    seen = 1;
                    if (o_ready) begin
                        void'(q.pop_front());
                        seen = 0;
                    end
                end
            end
            if (i_valid && i_ready) begin
                logic [14:0] r;
                exp_t e;
                r = model(i_data);
                e.d = r[13:0];
                e.z = r[14];
                e.lat = r[14] ? 2 : 10;
                e.acc = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic send(logic [63:0] x);
        int n = 0;
        while (!i_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_ready", i_ready, 1);
        i_valid = 1'b1;
        i_data = x;
        @(posedge clk); #1;
        i_valid = 1'b0;
        check("norm_iready", i_ready, 0);
        check("norm_busy", busy, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!o_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("valid_timeout", o_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] vec [12];
        logic [14:0] r;
        int nv;
        vec = '{64'd1, 64'd3, 64'd1 << 40, 64'd0, '1, 64'd1 << 63,
                64'd2, 64'd5, 64'd1000, 64'd12345, 64'h0123_4567_89AB_CDEF, 64'd255};
        rst = 1'b1; i_valid = 1'b0; i_data = '0; o_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_iready", i_ready, 1);
        check("rst_ovalid", o_valid, 0);
        check("rst_odata", o_data, 0);
        check("rst_ozero", o_zero, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        check("model_1", model(64'd1), 15'h0000);
        check("model_3", model(64'd3), 15'h0195);
        check("model_2p40", model(64'd1 << 40), 15'h2800);
        check("model_0", model(64'd0), 15'h4000);
        check("model_max", model('1), 15'h3FFF);
        check("model_2p63", model(64'd1 << 63), 15'h3F00);
        check("model_1024", model(64'd1024), 15'h0A00);

        foreach (vec[i]) begin
            send(vec[i]);
            wait_idle();
        end

        send(64'd3);
        wait_valid();
        check("lit_3", o_data, 14'h0195);
        wait_idle();

        o_ready = 1'b0;
        send(64'hDEAD_BEEF);
        wait_valid();
        r = model(64'hDEAD_BEEF);
        i_valid = 1'b1;
        i_data = 64'd77;
        repeat (20) begin
            @(posedge clk); #1;
            check("bp_hold", o_data, r[13:0]);
            check("bp_valid", o_valid, 1);
            check("bp_iready", i_ready, 0);
        end
        o_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_iready", i_ready, 1);
        check("bp_release_ovalid", o_valid, 0);
        @(posedge clk); #1;
        check("bp_second_accept", busy, 1);
        i_valid = 1'b0;
        wait_idle();

        send(64'd12345);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_iready", i_ready, 1);
        check("midrst_ovalid", o_valid, 0);
        check("midrst_odata", o_data, 0);
        check("midrst_ozero", o_zero, 0);
        check("midrst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        nv = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (o_valid) nv++;
        end
        check("midrst_no_valid", nv, 0);
        send(64'd1024);
        wait_valid();
        check("lit_1024", o_data, 14'h0A00);
        wait_idle();

        repeat (2) @(posedge clk);
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
